alu_result_mux_reg: RTL

Parametrised, registered successor to the ALU result selector. It selects one of NUM_IN WIDTH-bit functional-unit results by operation code, then registers the result with zero/negative flags into a single-entry output stage with a valid/ready handshake. Out-of-range operation codes are detected and flagged with a sticky error instead of holding stale data. Sits between the ALU functional units and the writeback/register-file stage.

---
 rtl/alu_mux_pkg.sv | 11 +
 rtl/alu_sel_comb.sv | 26 ++
 rtl/alu_result_mux_reg.sv | 69 ++++++
 3 files changed

// File: rtl/alu_mux_pkg.sv
// Shared defaults and operation codes for the ALU result selector slice.
package alu_mux_pkg;
  localparam int unsigned ALU_MUX_WIDTH_DEF  = 32;
  localparam int unsigned ALU_MUX_NUM_IN_DEF = 5;

  localparam int unsigned OP_IN0 = 0;
  localparam int unsigned OP_IN1 = 1;
  localparam int unsigned OP_IN2 = 2;
  localparam int unsigned OP_IN3 = 3;
  localparam int unsigned OP_IN4 = 4;
endpackage

// File: rtl/alu_sel_comb.sv
// Combinational N-way result select; out-of-range codes yield zero data and op_illegal.
module alu_sel_comb
  import alu_mux_pkg::*;
#(
  parameter int unsigned WIDTH  = ALU_MUX_WIDTH_DEF,
  parameter int unsigned NUM_IN = ALU_MUX_NUM_IN_DEF,
  localparam int unsigned SEL_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]        operation,
  output logic [WIDTH-1:0]        result,
  output logic                    op_illegal
);

  always_comb begin
    result     = '0;
    op_illegal = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (32'(operation) == k) begin
        result     = in_flat[k*WIDTH +: WIDTH];
        op_illegal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_result_mux_reg.sv
// Registered ALU result selector: single-entry output stage with valid/ready,
// zero/negative flags and a sticky illegal-operation error.
module alu_result_mux_reg
  import alu_mux_pkg::*;
#(
  parameter int unsigned WIDTH  = ALU_MUX_WIDTH_DEF,
  parameter int unsigned NUM_IN = ALU_MUX_NUM_IN_DEF,
  localparam int unsigned SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_flat,
  input  logic [SEL_W-1:0]        operation,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    zero,
  output logic                    neg,
  output logic                    op_err,
  input  logic                    err_clr
);

  logic [WIDTH-1:0] sel_result;
  logic             sel_illegal;
  logic             accept;

  alu_sel_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_sel (
    .in_flat    (in_flat),
    .operation  (operation),
    .result     (sel_result),
    .op_illegal (sel_illegal)
  );

  // Stage frees up in the same cycle its current result is consumed.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      op_err    <= 1'b0;
    end else begin
      if (accept) begin
        out       <= sel_result;
        zero      <= (sel_result == '0);
        neg       <= sel_result[WIDTH-1];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Setting on an accepted illegal op takes priority over err_clr.
      if (accept && sel_illegal) begin
        op_err <= 1'b1;
      end else if (err_clr) begin
        op_err <= 1'b0;
      end
    end
  end

endmodule
